// File: rtl/ripple_carry_4bit.sv
// Registered ripple-carry adder: a + b + cin through a chain of WIDTH
// full-adder cells, with registered sum/cout/ovf/zero flags and out_valid.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   a, b         unsigned operands (WIDTH bits)
//   cin          carry into bit 0
//   in_valid     sample a/b/cin on this edge
//   sum, cout    registered {cout, sum} = a + b + cin
//   ovf          registered signed overflow (carry into MSB ^ carry out)
//   zero         registered sum == 0 (cout ignored)
//   out_valid    one-cycle strobe per accepted operation

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

module ripple_carry_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  // c[i] is the carry into stage i; c[WIDTH] is the carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             ovf_n;
  logic             zero_n;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Signed overflow: carry into the sign bit disagrees with carry out.
  assign ovf_n  = c[WIDTH-1] ^ c[WIDTH];
  assign zero_n = (s == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
        ovf  <= ovf_n;
        zero <= zero_n;
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_4bit.sv
// Self-checking bench for ripple_carry_4bit: directed sweeps, overflow,
// hold, async reset, full 512-case sweep and random traffic.

module tb_ripple_carry_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       out_valid;

  int n_chk;
  int n_fail;

  logic [3:0] e_sum;
  logic       e_cout;
  logic       e_ovf;
  logic       e_zero;
  logic       e_vld;

  ripple_carry_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed range check for overflow.
  task automatic model(input int ia, input int ib, input int ic);
    int tot;
    int sa;
    int sb;
    int st;
    tot    = ia + ib + ic;
    sa     = (ia >= 8) ? ia - 16 : ia;
    sb     = (ib >= 8) ? ib - 16 : ib;
    st     = sa + sb + ic;
    e_sum  = 4'(tot % 16);
    e_cout = (tot >= 16);
    e_ovf  = (st > 7) || (st < -8);
    e_zero = ((tot % 16) == 0);
  endtask

  task automatic check(input string tag);
    n_chk++;
    assert (sum === e_sum) else begin
      n_fail++;
      $error("FAIL %s sum: got %0d want %0d", tag, sum, e_sum);
    end
    n_chk++;
    assert (cout === e_cout) else begin
      n_fail++;
      $error("FAIL %s cout: got %b want %b", tag, cout, e_cout);
    end
    n_chk++;
    assert (ovf === e_ovf) else begin
      n_fail++;
      $error("FAIL %s ovf: got %b want %b", tag, ovf, e_ovf);
    end
    n_chk++;
    assert (zero === e_zero) else begin
      n_fail++;
      $error("FAIL %s zero: got %b want %b", tag, zero, e_zero);
    end
    n_chk++;
    assert (out_valid === e_vld) else begin
      n_fail++;
      $error("FAIL %s out_valid: got %b want %b", tag, out_valid, e_vld);
    end
  endtask

  task automatic step(input int ia, input int ib, input int ic,
                      input logic v, input string tag);
    @(negedge clk);
    a        = 4'(ia);
    b        = 4'(ib);
    cin      = ic[0];
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) model(ia, ib, ic);
    e_vld = v;
    check(tag);
  endtask

  task automatic clr_model();
    e_sum  = '0;
    e_cout = 1'b0;
    e_ovf  = 1'b0;
    e_zero = 1'b0;
    e_vld  = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    in_valid = 1'b0;
    clr_model();
    #2;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 2; k++)
        step(0, j, k, 1'b1, "sweep_b");

    for (int j = 1; j < 16; j++)
      for (int k = 0; k < 2; k++)
        step(j, 15, k, 1'b1, "sweep_a");

    step(7, 1, 0, 1'b1, "ovf_7_1");
    step(8, 8, 0, 1'b1, "ovf_8_8");
    step(15, 1, 0, 1'b1, "ovf_15_1");
    step(15, 15, 1, 1'b1, "max");

    step(3, 4, 1, 1'b1, "hold_load");
    for (int j = 0; j < 3; j++)
      step($urandom_range(15), $urandom_range(15),
           $urandom_range(1), 1'b0, "hold");

    step(15, 15, 1, 1'b1, "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clr_model();
    check("async_rst");
    #2;
    rst_n = 1'b1;
    step(2, 2, 0, 1'b1, "post_rst");

    for (int j = 0; j < 512; j++)
      step(j % 16, (j / 16) % 16, j / 256, 1'b1, "full");

    for (int j = 0; j < 300; j++)
      step($urandom_range(15), $urandom_range(15), $urandom_range(1),
           1'($urandom_range(1)), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
